scm_frame_ctrl: RTL and testbench

Frame sequencer for the subcarrier mapper that sits between the beamformer output stream and the two IFFT input streams. Given a frame configuration, it opens the beamformer-to-mapper stream for exactly the programmed number of symbols and holds the mapper's start level for the whole frame. It then closes the input and monitors both IFFT-side streams until the programmed number of output beats has drained. It reports done, configuration error and drain timeout to the control plane.

---
 rtl/scm_frame_ctrl.sv | 115 +++++++++++
 tb/tb_scm_frame_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scm_frame_ctrl.sv
// scm_frame_ctrl: frame sequencer gating the beamformer-to-mapper stream and
// tracking IFFT-side drain, with done, config-error and timeout reporting.
module scm_frame_ctrl #(
    parameter int NSYM_W  = 8,
    parameter int NIN_W   = 12,
    parameter int NOUT_W  = 20,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              go,
    input  logic              abort,
    input  logic [NSYM_W-1:0] cfg_nsym,
    input  logic [NIN_W-1:0]  cfg_nin,
    input  logic [NOUT_W-1:0] cfg_nout,
    input  logic              bfo_tvld,
    output logic              bfo_trdy,
    output logic              scm_tvld,
    input  logic              scm_trdy,
    input  logic              ifia_tvld,
    input  logic              ifia_trdy,
    input  logic              ifib_tvld,
    input  logic              ifib_trdy,
    output logic              start_level,
    output logic              busy,
    output logic              done,
    output logic              err_cfg,
    output logic              err_timeout,
    output logic [NSYM_W-1:0] sym_cnt
);
    localparam int IDL_W = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [NSYM_W-1:0] nsym_q;
    logic [NIN_W-1:0]  nin_q, beat_cnt;
    logic [NOUT_W-1:0] nout_q, cnt_a, cnt_b, cnt_a_nx, cnt_b_nx;
    logic [IDL_W-1:0]  idle_cnt;
    logic run, in_beat, beat_a, beat_b, count_out, cfg_ok, accept;
    logic sym_end, frame_end, drained, timed_out;

    assign run       = state == RUN;
    assign bfo_trdy  = run & scm_trdy;
    assign scm_tvld  = run & bfo_tvld;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign in_beat   = bfo_tvld & scm_trdy & run;
    assign beat_a    = ifia_tvld & ifia_trdy;
    assign beat_b    = ifib_tvld & ifib_trdy;
    assign count_out = run | (state == DRAIN);
    assign cnt_a_nx  = (count_out && beat_a && cnt_a != nout_q) ? cnt_a + 1'b1 : cnt_a;
    assign cnt_b_nx  = (count_out && beat_b && cnt_b != nout_q) ? cnt_b + 1'b1 : cnt_b;
    assign cfg_ok    = cfg_nsym != '0 && cfg_nin != '0;
    assign accept    = state == IDLE && go && cfg_ok;
    assign sym_end   = in_beat && beat_cnt == nin_q - 1'b1;
    assign frame_end = sym_end && sym_cnt == nsym_q - 1'b1;
    // drain completion looks at counts including this cycle's beats
    assign drained   = cnt_a_nx == nout_q && cnt_b_nx == nout_q;
    assign timed_out = idle_cnt == IDL_W'(TIMEOUT - 1) && !(beat_a | beat_b);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = accept ? RUN : IDLE;
            RUN:   state_nx = frame_end ? DRAIN : RUN;
            DRAIN: state_nx = (drained || timed_out) ? DONE : DRAIN;
            DONE:  state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= IDLE;
            start_level <= 1'b0;
            err_cfg     <= 1'b0;
            err_timeout <= 1'b0;
            nsym_q      <= '0;
            nin_q       <= '0;
            nout_q      <= '0;
            beat_cnt    <= '0;
            sym_cnt     <= '0;
            cnt_a       <= '0;
            cnt_b       <= '0;
            idle_cnt    <= '0;
        end else begin
            state       <= state_nx;
            start_level <= state_nx inside {RUN, DRAIN};
            err_cfg     <= state == IDLE && go && !cfg_ok && !abort;
            if (abort) begin
                beat_cnt <= '0;
                sym_cnt  <= '0;
                cnt_a    <= '0;
                cnt_b    <= '0;
                idle_cnt <= '0;
            end else if (accept) begin
                nsym_q      <= cfg_nsym;
                nin_q       <= cfg_nin;
                nout_q      <= cfg_nout;
                beat_cnt    <= '0;
                sym_cnt     <= '0;
                cnt_a       <= '0;
                cnt_b       <= '0;
                idle_cnt    <= '0;
                err_timeout <= 1'b0;
            end else begin
                if (in_beat) beat_cnt <= sym_end ? '0 : beat_cnt + 1'b1;
                if (sym_end) sym_cnt <= sym_cnt + 1'b1;
                cnt_a    <= cnt_a_nx;
                cnt_b    <= cnt_b_nx;
                idle_cnt <= (state == DRAIN && !(beat_a | beat_b)) ? idle_cnt + 1'b1 : '0;
                if (state == DRAIN && !drained && timed_out) err_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_scm_frame_ctrl.sv
// tb_scm_frame_ctrl: directed scenario tests for the frame sequencer.
module tb_scm_frame_ctrl;
    logic clk = 1'b0, srst = 1'b0, go = 1'b0, abort = 1'b0;
    logic [7:0]  cfg_nsym = '0;
    logic [11:0] cfg_nin = '0;
    logic [19:0] cfg_nout = '0;
    logic bfo_tvld = 1'b0, scm_trdy = 1'b0;
    logic ifia_tvld = 1'b0, ifia_trdy = 1'b0, ifib_tvld = 1'b0, ifib_trdy = 1'b0;
    logic bfo_trdy, scm_tvld, start_level, busy, done, err_cfg, err_timeout;
    logic [7:0] sym_cnt;
    int checks = 0, failures = 0;
    int n_in = 0, n_done = 0, n_sl = 0;
    wire [4:0] st = {busy, start_level, done, err_cfg, err_timeout};
    wire [1:0] gate = {bfo_trdy, scm_tvld};

    scm_frame_ctrl #(.NSYM_W(8), .NIN_W(12), .NOUT_W(20), .TIMEOUT(16)) dut (
        .clk(clk), .srst(srst), .go(go), .abort(abort),
        .cfg_nsym(cfg_nsym), .cfg_nin(cfg_nin), .cfg_nout(cfg_nout),
        .bfo_tvld(bfo_tvld), .bfo_trdy(bfo_trdy), .scm_tvld(scm_tvld), .scm_trdy(scm_trdy),
        .ifia_tvld(ifia_tvld), .ifia_trdy(ifia_trdy), .ifib_tvld(ifib_tvld), .ifib_trdy(ifib_trdy),
        .start_level(start_level), .busy(busy), .done(done), .err_cfg(err_cfg),
        .err_timeout(err_timeout), .sym_cnt(sym_cnt)
    );

    always #5 clk = ~clk;

    // beats, done pulses and start_level-high cycles, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        #2;
        if (bfo_tvld && bfo_trdy) n_in++;
        if (done) n_done++;
        if (start_level) n_sl++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_ifi(input logic a, input logic b);
        {ifia_tvld, ifia_trdy} = {a, a};
        {ifib_tvld, ifib_trdy} = {b, b};
    endtask

    task automatic start(input int ns, input int ni, input int no);
        cfg_nsym = 8'(ns);
        cfg_nin  = 12'(ni);
        cfg_nout = 20'(no);
        go = 1'b1;
    endtask

    task automatic test_reset;
        srst = 1'b1;
        bfo_tvld = 1'b1;
        scm_trdy = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (st !== 5'b0) begin failures++; $display("FAIL reset_status got=%b exp=%b", st, 5'b0); end
        checks++;
        if (gate !== 2'b0) begin failures++; $display("FAIL reset_gate got=%b exp=%b", gate, 2'b0); end
        checks++;
        if (sym_cnt !== 8'd0) begin failures++; $display("FAIL reset_sym_cnt got=%0d exp=0", sym_cnt); end
        srst = 1'b0;
        bfo_tvld = 1'b0;
        scm_trdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal;
        int b_in = n_in, b_done = n_done, b_sl = n_sl;
        start(3, 4, 6);
        bfo_tvld = 1'b1;
        scm_trdy = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            if (c == 0) begin
                go = 1'b0;
                set_ifi(1'b1, 1'b1);
                #1;
                checks++;
                if ({busy, start_level, bfo_trdy} !== 3'b111) begin
                    failures++; $display("FAIL nom_open got=%b exp=111", {busy, start_level, bfo_trdy});
                end
            end
            if (c == 6) set_ifi(1'b0, 1'b0);
            if (c == 12) begin
                #1;
                checks++;
                if ({busy, start_level, scm_tvld} !== 3'b110) begin
                    failures++; $display("FAIL nom_drain got=%b exp=110", {busy, start_level, scm_tvld});
                end
            end
            if (c == 13) begin
                checks++;
                if ({done, start_level} !== 2'b10) begin
                    failures++; $display("FAIL nom_done got=%b exp=10", {done, start_level});
                end
            end
            if (c == 14) begin
                checks++;
                if ({busy, done} !== 2'b00) begin failures++; $display("FAIL nom_idle got=%b exp=00", {busy, done}); end
            end
        end
        checks++;
        if (n_in - b_in != 12) begin failures++; $display("FAIL nom_beats got=%0d exp=12", n_in - b_in); end
        checks++;
        if (sym_cnt !== 8'd3) begin failures++; $display("FAIL nom_sym_cnt got=%0d exp=3", sym_cnt); end
        checks++;
        if (n_done - b_done != 1) begin failures++; $display("FAIL nom_done_count got=%0d exp=1", n_done - b_done); end
        checks++;
        if (n_sl - b_sl != 13) begin failures++; $display("FAIL nom_start_cycles got=%0d exp=13", n_sl - b_sl); end
        checks++;
        if (err_timeout !== 1'b0) begin failures++; $display("FAIL nom_timeout got=%b exp=0", err_timeout); end
    endtask

    task automatic test_backpressure;
        int b_in = n_in, exp_in = 0, cyc = 0;
        start(3, 4, 6);
        bfo_tvld = 1'b0;
        scm_trdy = 1'b0;
        @(negedge clk);
        go = 1'b0;
        set_ifi(1'b1, 1'b1);
        while (exp_in < 12 && cyc < 200) begin
            scm_trdy = (cyc % 2) == 0;
            bfo_tvld = 1'($urandom_range(0, 1));
            if (cyc == 6) set_ifi(1'b0, 1'b0);
            #1;
            checks++;
            if (gate !== {scm_trdy, bfo_tvld}) begin
                failures++; $display("FAIL bp_gate cyc=%0d got=%b exp=%b", cyc, gate, {scm_trdy, bfo_tvld});
            end
            if (bfo_tvld && scm_trdy) exp_in++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (exp_in != 12) begin failures++; $display("FAIL bp_budget got=%0d exp=12", exp_in); end
        bfo_tvld = 1'b1;
        scm_trdy = 1'b1;
        #1;
        checks++;
        if ({gate, start_level, busy} !== 4'b0011) begin
            failures++; $display("FAIL bp_closed got=%b exp=0011", {gate, start_level, busy});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL bp_done got=%b exp=1", done); end
        @(negedge clk);
        checks++;
        if (n_in - b_in != 12) begin failures++; $display("FAIL bp_beats got=%0d exp=12", n_in - b_in); end
        checks++;
        if ({busy, sym_cnt} !== {1'b0, 8'd3}) begin
            failures++; $display("FAIL bp_end got=%b/%0d exp=0/3", busy, sym_cnt);
        end
    endtask

    task automatic test_bad_cfg;
        start(0, 4, 6);
        @(negedge clk);
        go = 1'b0;
        checks++;
        if (st !== 5'b00010) begin failures++; $display("FAIL bad_nsym got=%b exp=00010", st); end
        @(negedge clk);
        checks++;
        if (err_cfg !== 1'b0) begin failures++; $display("FAIL bad_pulse got=%b exp=0", err_cfg); end
        start(3, 0, 6);
        @(negedge clk);
        go = 1'b0;
        checks++;
        if (st !== 5'b00010) begin failures++; $display("FAIL bad_nin got=%b exp=00010", st); end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        start(1, 2, 6);
        bfo_tvld = 1'b1;
        scm_trdy = 1'b1;
        set_ifi(1'b1, 1'b1);
        for (int c = 0; c <= 26; c++) begin
            @(negedge clk);
            if (c == 0) go = 1'b0;
            if (c == 5) set_ifi(1'b1, 1'b0);
            if (c == 6) set_ifi(1'b0, 1'b0);
            if (c == 21) begin
                checks++;
                if (st !== 5'b11000) begin failures++; $display("FAIL to_wait got=%b exp=11000", st); end
            end
            if (c == 22) begin
                checks++;
                if (st !== 5'b10101) begin failures++; $display("FAIL to_done got=%b exp=10101", st); end
            end
            if (c == 23) begin
                checks++;
                if ({st, sym_cnt} !== {5'b00001, 8'd1}) begin
                    failures++; $display("FAIL to_idle got=%b/%0d exp=00001/1", st, sym_cnt);
                end
                start(0, 2, 6);
            end
            if (c == 24) begin
                checks++;
                if (st !== 5'b00011) begin failures++; $display("FAIL to_badgo got=%b exp=00011", st); end
                start(1, 2, 6);
            end
            if (c == 25) begin
                go = 1'b0;
                checks++;
                if (st !== 5'b11000) begin failures++; $display("FAIL to_clear got=%b exp=11000", st); end
                abort = 1'b1;
            end
            if (c == 26) begin
                abort = 1'b0;
                checks++;
                if (busy !== 1'b0) begin failures++; $display("FAIL to_abort got=%b exp=0", busy); end
            end
        end
    endtask

    task automatic test_abort;
        int b_in = n_in, b_done = n_done;
        start(3, 4, 6);
        bfo_tvld = 1'b1;
        scm_trdy = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c == 0) go = 1'b0;
            if (c == 6) begin
                checks++;
                if (sym_cnt !== 8'd1) begin failures++; $display("FAIL ab_mid_sym got=%0d exp=1", sym_cnt); end
                abort = 1'b1;
            end
            if (c == 7) begin
                abort = 1'b0;
                #1;
                checks++;
                if ({st, gate, sym_cnt} !== {5'b0, 2'b0, 8'd0}) begin
                    failures++; $display("FAIL ab_idle got=%b/%b/%0d exp=00000/00/0", st, gate, sym_cnt);
                end
            end
        end
        checks++;
        if (n_in - b_in != 7) begin failures++; $display("FAIL ab_beats got=%0d exp=7", n_in - b_in); end
        checks++;
        if (n_done - b_done != 0) begin failures++; $display("FAIL ab_no_done got=%0d exp=0", n_done - b_done); end
    endtask

    task automatic test_back_to_back;
        int b_done = n_done;
        start(1, 1, 0);
        bfo_tvld = 1'b1;
        scm_trdy = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c == 0) go = 1'b0;
            if (c == 2) begin
                checks++;
                if (done !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=%b exp=1", done); end
                go = 1'b1;
            end
            if (c == 3) begin
                checks++;
                if (busy !== 1'b0) begin failures++; $display("FAIL b2b_ignored got=%b exp=0", busy); end
            end
            if (c == 4) begin
                go = 1'b0;
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy); end
            end
            if (c == 6) begin
                checks++;
                if (done !== 1'b1) begin failures++; $display("FAIL b2b_done2 got=%b exp=1", done); end
            end
        end
        checks++;
        if (n_done - b_done != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", n_done - b_done); end
    endtask

    task automatic test_reset_drain;
        logic seen = 1'b0;
        start(1, 2, 4);
        bfo_tvld = 1'b1;
        scm_trdy = 1'b1;
        set_ifi(1'b0, 1'b0);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c == 0) go = 1'b0;
            if (c == 3) begin
                checks++;
                if ({busy, start_level} !== 2'b11) begin
                    failures++; $display("FAIL rd_drain got=%b exp=11", {busy, start_level});
                end
                srst = 1'b1;
            end
        end
        #1;
        checks++;
        if ({st, gate, sym_cnt} !== {5'b0, 2'b0, 8'd0}) begin
            failures++; $display("FAIL rd_reset got=%b/%b/%0d exp=00000/00/0", st, gate, sym_cnt);
        end
        srst = 1'b0;
        start(1, 2, 2);
        set_ifi(1'b1, 1'b1);
        for (int w = 0; w < 40 && !seen; w++) begin
            @(negedge clk);
            if (w == 0) go = 1'b0;
            if (w == 2) set_ifi(1'b0, 1'b0);
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin failures++; $display("FAIL rd_fresh_done got=%b exp=1", seen); end
        checks++;
        if ({sym_cnt, err_timeout} !== {8'd1, 1'b0}) begin
            failures++; $display("FAIL rd_fresh_end got=%0d/%b exp=1/0", sym_cnt, err_timeout);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_nominal;
        test_backpressure;
        test_bad_cfg;
        test_timeout;
        test_abort;
        test_back_to_back;
        test_reset_drain;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
